dry_gascon128: RTL and testbench
================================

DRY_GASCON128 -- requirements
Module: dry_gascon128

Interface
REQ-001 SHALL have parameter-free interface; rounds supplied per operation on a port.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 clk_en  in  1  all state updates, including reset release behaviour after rst, occur only when high.
REQ-005 din  in  32  write data word.
REQ-006 ds  in  4  domain separator for F, sampled at start.
REQ-007 wr_i / wr_c / wr_x  in  1 each  write streams: input I (4 words), state C (10 words), key X (4 words).
REQ-008 rounds  in  4  G rounds per operation, sampled at start (7 and 11 in use).
REQ-009 start  in  1  one-cycle launch pulse.
REQ-010 rd_r / rd_c  in  1 each  read streams: R (4 words), C (10 words).
REQ-011 dout  out  32  registered read word.
REQ-012 idle  out  1  high when no operation is running.

Function
REQ-013 SHALL hold registers c[319:0] (5x64-bit Gascon words), x[127:0], i[127:0], r[127:0], with hierarchical names c and x.
REQ-014 Word k of any vector = bits [32k+31:32k]. Streams are LSB word first; byte string b0..bn maps b0 to bits [7:0].
REQ-015 Each wr_* cycle shifts din in at the top: c <= {din, c[319:32]} (x, i likewise at 128 bits). After N consecutive cycles the vector equals the written value. No pointer is kept.
REQ-016 Each rd_* cycle: dout <= low word; vector rotates right by 32. The first word is valid one clock after rd asserts. A full 10-word (C) or 4-word (R) read restores the register.
REQ-017 wr_i sets flag i_pending.
REQ-018 If start is accepted with i_pending: perform DryGASCON128 F = Mix128(C, X, I||ds) then G(rounds). Clear i_pending.
REQ-019 If start is accepted without i_pending: perform G(rounds) only.
REQ-020 Mix128: 132-bit I||ds, zero-padded to 140 bits, is consumed in 14 steps of 10 bits.
REQ-021 Each Mix step splits its 10 bits into five 2-bit indices. C word j low 32 bits ^= x word idx_j.
REQ-022 Each Mix step except the last is followed in the same cycle by CoreRound(round 0). The last Mix step shares a cycle with G round 0.
REQ-023 G: r cleared at G start. For n = 0..rounds-1: C = CoreRound(C, n); r ^= Accumulate(C).
REQ-024 CoreRound = Gascon round per DryGASCON v1.1: constant into word 2, 5-bit S-box, interleaved-rotation linear layer. Accumulate per DryGASCON128.
REQ-025 Throughput: one core round per cycle.
REQ-026 Latency: F = 14 + rounds − 1 cycles; G = rounds cycles. idle falls at the edge accepting start and rises after the last round.
REQ-027 FSM states: IDLE, MIX, GROUNDS. IDLE→MIX on start with i_pending; IDLE→GROUNDS on start without it. MIX→GROUNDS after step 13. GROUNDS→IDLE after the last round.
REQ-028 While busy: wr_*, rd_*, start ignored; dout holds.
REQ-029 In IDLE, one action per cycle, priority wr_c > wr_x > wr_i > rd_c > rd_r > start.
REQ-030 rounds = 0: G does no rounds; r = 0; idle returns the next cycle.

Reset
REQ-031 rst clears c, x, i, r, dout, i_pending; FSM to IDLE; idle = 1.
REQ-032 rst mid-operation aborts immediately.

Structure
REQ-033 Package dry_gascon128_pkg holds: le_to_int (320-bit), le_to_int128, compute_ds(pad, domain, final) = {domain[1:0], final, pad}, round-constant function, S-box, Accumulate, DS constants (PAD=1, FINAL=1, DS_S=2, DS_D=1, DS_A=2, DS_M=3).
REQ-034 One combinational sub-module gascon_core_round (C in, round index, optional mix enable/indices; C out).

Verification
REQ-035 Write X = le 28292A2B…3637, C = le 000102…2627 → x and c match immediately after the last word; C read back equals value and is unchanged.
REQ-036 F with ds=6, rounds=11, I = le F0F1…FEFF → R = le F1FBA3D719B00A49BF170F832EB7649F. Rewrite C, repeat → same R.
REQ-037 Hash init (X = le A4093822299F31D0082EFA98EC4E6C89, C = le 243F6A8885A308D3 13198A2E03707344 repeated) then F: ds = compute_ds(1,2,1), rounds 7, I = le 0100…00 → R = le 1EDC77386E20A37C721D6E77ADABB9C4. Then G(7) → le 830F199F5ED25284A13C1D84B9FC257A.
REQ-038 Same init, I = le 00010203040506070100000000000000 → R = le CDE2DEE0235345CBFA51EC2CE5743571. Then G → le 8EC0133EC2756E035FA404C1CE511E24.
REQ-039 Same init: F(ds=0, I = le 000102…0F), then F(compute_ds(1,2,1), I = le 1001…00) → le 20CDB78974D692100612978096CCFE82. Then G → le E39F15969F493FAD8FA870F93B7252EA.
REQ-040 Assert rst mid-F → idle = 1 and c = 0. Writes while busy do not alter x or c.

Source files
------------

// File: rtl/dry_gascon128_pkg.sv
// rtl/dry_gascon128_pkg.sv - shared types and Gascon/DryGASCON128 helper functions
package dry_gascon128_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MIX     = 2'd1,
        ST_GROUNDS = 2'd2
    } state_t;

    localparam logic [3:0] MIX_LAST = 4'd13;

    localparam logic       PAD   = 1'b1;
    localparam logic       FINAL = 1'b1;
    localparam logic [1:0] DS_S  = 2'd2;
    localparam logic [1:0] DS_D  = 2'd1;
    localparam logic [1:0] DS_A  = 2'd2;
    localparam logic [1:0] DS_M  = 2'd3;

    // Byte string written MSB-first in a literal -> vector with b0 at bits [7:0]
    function automatic logic [319:0] le_to_int(input logic [319:0] v);
        logic [319:0] res;
        for (int k = 0; k < 40; k++) res[8*k +: 8] = v[8*(39-k) +: 8];
        return res;
    endfunction

    function automatic logic [127:0] le_to_int128(input logic [127:0] v);
        logic [127:0] res;
        for (int k = 0; k < 16; k++) res[8*k +: 8] = v[8*(15-k) +: 8];
        return res;
    endfunction

    function automatic logic [3:0] compute_ds(input logic pad, input logic [1:0] domain,
                                              input logic fin);
        return {domain, fin, pad};
    endfunction

    function automatic logic [63:0] round_const(input logic [3:0] n);
        return {56'd0, 4'hF - n, n};
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] v, input int k);
        logic [63:0] d;
        d = {v, v} >> k;
        return d[31:0];
    endfunction

    // 64-bit rotate on a bit-interleaved word: low half = even bits, high half = odd bits
    function automatic logic [63:0] rotr_il(input logic [63:0] v, input int s);
        logic [31:0] ev;
        logic [31:0] od;
        if (s % 2 == 1) begin
            ev = rotr32(v[63:32], s / 2);
            od = rotr32(v[31:0], (s / 2 + 1) % 32);
        end else begin
            ev = rotr32(v[31:0], s / 2);
            od = rotr32(v[63:32], s / 2);
        end
        return {od, ev};
    endfunction

    function automatic logic [319:0] gascon_sbox(input logic [319:0] c);
        logic [63:0]  w [5];
        logic [63:0]  t [5];
        logic [319:0] res;
        for (int k = 0; k < 5; k++) w[k] = c[64*k +: 64];
        w[0] ^= w[4];
        w[4] ^= w[3];
        w[2] ^= w[1];
        for (int k = 0; k < 5; k++) t[k] = ~w[k] & w[(k+1)%5];
        for (int k = 0; k < 5; k++) w[k] ^= t[(k+1)%5];
        w[1] ^= w[0];
        w[0] ^= w[4];
        w[3] ^= w[2];
        w[2] = ~w[2];
        for (int k = 0; k < 5; k++) res[64*k +: 64] = w[k];
        return res;
    endfunction

    // Rate-sized fold of the capacity; the second chunk is rotated by one 32-bit word
    function automatic logic [127:0] accumulate(input logic [319:0] c);
        logic [127:0] a;
        for (int j = 0; j < 4; j++)
            a[32*j +: 32] = c[32*j +: 32] ^ c[128 + 32*((j+1)%4) +: 32];
        return a;
    endfunction

endpackage

// File: rtl/dry_gascon128_core_round.sv
// rtl/dry_gascon128_core_round.sv - combinational optional Mix128 step followed by optional Gascon round
module gascon_core_round
    import dry_gascon128_pkg::*;
(
    input  logic [319:0] i_c,
    input  logic [127:0] i_x,
    input  logic         i_mix_en,
    input  logic [9:0]   i_mix_bits,
    input  logic         i_round_en,
    input  logic [3:0]   i_round,
    output logic [319:0] o_c
);

    logic [319:0] w_mixed;
    logic [319:0] w_cst;
    logic [319:0] w_sb;
    logic [319:0] w_lin;

    always_comb begin
        w_mixed = i_c;
        if (i_mix_en)
            for (int j = 0; j < 5; j++)
                w_mixed[64*j +: 32] = i_c[64*j +: 32] ^ i_x[32*i_mix_bits[2*j +: 2] +: 32];
    end

    always_comb begin
        w_cst = w_mixed;
        w_cst[128 +: 64] = w_mixed[128 +: 64] ^ round_const(i_round);
    end

    assign w_sb = gascon_sbox(w_cst);

    assign w_lin[0   +: 64] = w_sb[0   +: 64] ^ rotr_il(w_sb[0   +: 64], 19) ^ rotr_il(w_sb[0   +: 64], 28);
    assign w_lin[64  +: 64] = w_sb[64  +: 64] ^ rotr_il(w_sb[64  +: 64], 61) ^ rotr_il(w_sb[64  +: 64], 38);
    assign w_lin[128 +: 64] = w_sb[128 +: 64] ^ rotr_il(w_sb[128 +: 64], 1)  ^ rotr_il(w_sb[128 +: 64], 6);
    assign w_lin[192 +: 64] = w_sb[192 +: 64] ^ rotr_il(w_sb[192 +: 64], 10) ^ rotr_il(w_sb[192 +: 64], 17);
    assign w_lin[256 +: 64] = w_sb[256 +: 64] ^ rotr_il(w_sb[256 +: 64], 7)  ^ rotr_il(w_sb[256 +: 64], 40);

    assign o_c = i_round_en ? w_lin : w_mixed;

endmodule

// File: rtl/dry_gascon128.sv
// rtl/dry_gascon128.sv - DryGASCON128 F/G engine with word-serial C/X/I load and C/R readout
module dry_gascon128
    import dry_gascon128_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] din,
    input  logic [3:0]  ds,
    input  logic        wr_i,
    input  logic        wr_c,
    input  logic        wr_x,
    input  logic [3:0]  rounds,
    input  logic        start,
    input  logic        rd_r,
    input  logic        rd_c,
    output logic [31:0] dout,
    output logic        idle
);

    logic [319:0] c;
    logic [127:0] x;
    logic [127:0] r_i;
    logic [127:0] r_r;
    logic [31:0]  r_dout;
    logic         r_pending;
    logic [3:0]   r_cnt;
    logic [3:0]   r_rounds;
    logic [3:0]   r_ds;
    state_t       r_state;

    state_t       w_next_state;
    logic         w_go;
    logic         w_mix_en;
    logic         w_round_en;
    logic [3:0]   w_round_idx;
    logic [159:0] w_mix_vec;
    logic [9:0]   w_mix_bits;
    logic [319:0] w_core_c;

    assign w_go       = start & ~wr_c & ~wr_x & ~wr_i & ~rd_c & ~rd_r;
    assign w_mix_vec  = {28'd0, r_ds, r_i};
    assign w_mix_bits = w_mix_vec[10*r_cnt +: 10];
    assign dout       = r_dout;

    gascon_core_round u_core (
        .i_c        (c),
        .i_x        (x),
        .i_mix_en   (w_mix_en),
        .i_mix_bits (w_mix_bits),
        .i_round_en (w_round_en),
        .i_round    (w_round_idx),
        .o_c        (w_core_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else if (clk_en)
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_go) w_next_state = r_pending ? ST_MIX : ST_GROUNDS;
            ST_MIX:     if (r_cnt == MIX_LAST)
                            w_next_state = (r_rounds <= 4'd1) ? ST_IDLE : ST_GROUNDS;
            ST_GROUNDS: if ({1'b0, r_cnt} + 5'd1 >= {1'b0, r_rounds})
                            w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // The last mix step also carries G round 0 unless no rounds were requested
    always_comb begin
        idle        = 1'b0;
        w_mix_en    = 1'b0;
        w_round_en  = 1'b0;
        w_round_idx = 4'd0;
        case (r_state)
            ST_IDLE: idle = 1'b1;
            ST_MIX: begin
                w_mix_en   = 1'b1;
                w_round_en = (r_cnt != MIX_LAST) || (r_rounds != 4'd0);
            end
            ST_GROUNDS: begin
                w_round_en  = (r_cnt < r_rounds);
                w_round_idx = r_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c         <= '0;
            x         <= '0;
            r_i       <= '0;
            r_r       <= '0;
            r_dout    <= '0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_rounds  <= '0;
            r_ds      <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (wr_c) begin
                        c <= {din, c[319:32]};
                    end else if (wr_x) begin
                        x <= {din, x[127:32]};
                    end else if (wr_i) begin
                        r_i       <= {din, r_i[127:32]};
                        r_pending <= 1'b1;
                    end else if (rd_c) begin
                        r_dout <= c[31:0];
                        c      <= {c[31:0], c[319:32]};
                    end else if (rd_r) begin
                        r_dout <= r_r[31:0];
                        r_r    <= {r_r[31:0], r_r[127:32]};
                    end else if (start) begin
                        r_rounds  <= rounds;
                        r_ds      <= ds;
                        r_cnt     <= 4'd0;
                        r_r       <= '0;
                        r_pending <= 1'b0;
                    end
                end
                ST_MIX: begin
                    c <= w_core_c;
                    if (r_cnt == MIX_LAST) begin
                        r_cnt <= 4'd1;
                        if (w_round_en) r_r <= r_r ^ accumulate(w_core_c);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_GROUNDS: begin
                    if (w_round_en) begin
                        c   <= w_core_c;
                        r_r <= r_r ^ accumulate(w_core_c);
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dry_gascon128.sv
// tb/tb_dry_gascon128.sv - directed self-checking bench for dry_gascon128
module tb_dry_gascon128;
    import dry_gascon128_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [31:0] din;
    logic [3:0]  ds;
    logic        wr_i, wr_c, wr_x;
    logic [3:0]  rounds;
    logic        start;
    logic        rd_r, rd_c;
    logic [31:0] dout;
    logic        idle;

    int total = 0;
    int bad   = 0;

    logic [319:0] c_seq, c_hash, rd_val, c_save;
    logic [127:0] x_seq, x_hash;
    int           cyc;

    always #5 clk = ~clk;

    dry_gascon128 dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .din    (din),
        .ds     (ds),
        .wr_i   (wr_i),
        .wr_c   (wr_c),
        .wr_x   (wr_x),
        .rounds (rounds),
        .start  (start),
        .rd_r   (rd_r),
        .rd_c   (rd_c),
        .dout   (dout),
        .idle   (idle)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // which: 0 = C, 1 = X, 2 = I
    task automatic write_vec(input int which, input logic [319:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            din  = v[32*k +: 32];
            wr_c = (which == 0);
            wr_x = (which == 1);
            wr_i = (which == 2);
            tick();
        end
        wr_c = 1'b0;
        wr_x = 1'b0;
        wr_i = 1'b0;
    endtask

    task automatic read_vec(input logic from_c, input int n, output logic [319:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            rd_c = from_c;
            rd_r = ~from_c;
            tick();
            v[32*k +: 32] = dout;
        end
        rd_c = 1'b0;
        rd_r = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] d, input logic [3:0] nr, input logic noise,
                          output int n);
        ds     = d;
        rounds = nr;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_fall", {319'd0, idle}, 320'd0);
        n = 0;
        while (idle !== 1'b1 && n < 200) begin
            if (noise) begin
                din   = 32'hDEADBEEF;
                wr_c  = 1'b1;
                wr_x  = 1'b1;
                rd_c  = 1'b1;
                start = 1'b1;
            end
            tick();
            n++;
        end
        wr_c  = 1'b0;
        wr_x  = 1'b0;
        rd_c  = 1'b0;
        start = 1'b0;
    endtask

    task automatic hash_init;
        write_vec(1, {192'd0, x_hash}, 4);
        write_vec(0, c_hash, 10);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; din = '0; ds = '0; rounds = '0;
        wr_i = 1'b0; wr_c = 1'b0; wr_x = 1'b0; start = 1'b0; rd_r = 1'b0; rd_c = 1'b0;
        c_seq  = le_to_int(320'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F2021222324252627);
        x_seq  = le_to_int128(128'h28292A2B2C2D2E2F3031323334353637);
        c_hash = le_to_int(320'h243F6A8885A308D313198A2E03707344243F6A8885A308D313198A2E03707344243F6A8885A308D3);
        x_hash = le_to_int128(128'hA4093822299F31D0082EFA98EC4E6C89);
        tick();
        tick();
        chk("rst_c",    dut.c, 320'd0);
        chk("rst_x",    {192'd0, dut.x}, 320'd0);
        chk("rst_dout", {288'd0, dout}, 320'd0);
        chk("rst_idle", {319'd0, idle}, 320'd1);
        rst = 1'b0;
        tick();

        write_vec(1, {192'd0, x_seq}, 4);
        chk("wr_x", {192'd0, dut.x}, {192'd0, x_seq});
        write_vec(0, c_seq, 10);
        chk("wr_c", dut.c, c_seq);
        read_vec(1'b1, 10, rd_val);
        chk("rd_c_val", rd_val, c_seq);
        chk("rd_c_restore", dut.c, c_seq);

        clk_en = 1'b0;
        din = 32'h12345678;
        wr_c = 1'b1;
        tick();
        wr_c = 1'b0;
        clk_en = 1'b1;
        chk("clk_en_hold", dut.c, c_seq);

        write_vec(2, {192'd0, le_to_int128(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF)}, 4);
        run_op(4'd6, 4'd11, 1'b0, cyc);
        chk("f11_latency", 320'(cyc), 320'd24);
        read_vec(1'b0, 4, rd_val);
        chk("f11_r", rd_val, {192'd0, le_to_int128(128'hF1FBA3D719B00A49BF170F832EB7649F)});
        write_vec(0, c_seq, 10);
        write_vec(2, {192'd0, le_to_int128(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF)}, 4);
        run_op(4'd6, 4'd11, 1'b0, cyc);
        read_vec(1'b0, 4, rd_val);
        chk("f11_r_repeat", rd_val, {192'd0, le_to_int128(128'hF1FBA3D719B00A49BF170F832EB7649F)});

        hash_init();
        write_vec(2, {192'd0, le_to_int128(128'h01000000000000000000000000000000)}, 4);
        run_op(compute_ds(PAD, DS_S, FINAL), 4'd7, 1'b0, cyc);
        chk("f7_latency", 320'(cyc), 320'd20);
        read_vec(1'b0, 4, rd_val);
        chk("hash0_f", rd_val, {192'd0, le_to_int128(128'h1EDC77386E20A37C721D6E77ADABB9C4)});
        run_op(4'd0, 4'd7, 1'b0, cyc);
        chk("g7_latency", 320'(cyc), 320'd7);
        read_vec(1'b0, 4, rd_val);
        chk("hash0_g", rd_val, {192'd0, le_to_int128(128'h830F199F5ED25284A13C1D84B9FC257A)});

        hash_init();
        write_vec(2, {192'd0, le_to_int128(128'h00010203040506070100000000000000)}, 4);
        run_op(compute_ds(PAD, DS_S, FINAL), 4'd7, 1'b1, cyc);
        chk("busy_wr_x", {192'd0, dut.x}, {192'd0, x_hash});
        read_vec(1'b0, 4, rd_val);
        chk("hash8_f", rd_val, {192'd0, le_to_int128(128'hCDE2DEE0235345CBFA51EC2CE5743571)});
        run_op(4'd0, 4'd7, 1'b0, cyc);
        read_vec(1'b0, 4, rd_val);
        chk("hash8_g", rd_val, {192'd0, le_to_int128(128'h8EC0133EC2756E035FA404C1CE511E24)});

        hash_init();
        write_vec(2, {192'd0, le_to_int128(128'h000102030405060708090A0B0C0D0E0F)}, 4);
        run_op(4'd0, 4'd7, 1'b0, cyc);
        write_vec(2, {192'd0, le_to_int128(128'h10010000000000000000000000000000)}, 4);
        run_op(compute_ds(PAD, DS_S, FINAL), 4'd7, 1'b0, cyc);
        read_vec(1'b0, 4, rd_val);
        chk("hash17_f", rd_val, {192'd0, le_to_int128(128'h20CDB78974D692100612978096CCFE82)});
        run_op(4'd0, 4'd7, 1'b0, cyc);
        read_vec(1'b0, 4, rd_val);
        chk("hash17_g", rd_val, {192'd0, le_to_int128(128'hE39F15969F493FAD8FA870F93B7252EA)});

        c_save = dut.c;
        run_op(4'd0, 4'd0, 1'b0, cyc);
        chk("g0_latency", 320'(cyc), 320'd1);
        chk("g0_c", dut.c, c_save);
        read_vec(1'b0, 4, rd_val);
        chk("g0_r", rd_val, 320'd0);

        write_vec(0, c_seq, 10);
        din  = 32'hA5A55A5A;
        wr_c = 1'b1;
        wr_x = 1'b1;
        tick();
        wr_c = 1'b0;
        wr_x = 1'b0;
        chk("prio_x", {192'd0, dut.x}, {192'd0, x_hash});
        chk("prio_c", dut.c, {32'hA5A55A5A, c_seq[319:32]});

        write_vec(2, {192'd0, x_seq}, 4);
        ds = 4'd6;
        rounds = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("busy_pre_rst", {319'd0, idle}, 320'd0);
        rst = 1'b1;
        #1;
        chk("abort_idle", {319'd0, idle}, 320'd1);
        chk("abort_c", dut.c, 320'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_stays_idle", {319'd0, idle}, 320'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
